core_run_ctrl: RTL and testbench

CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

---
 rtl/core_run_ctrl_pkg.sv | 18 +
 rtl/core_run_counter.sv | 27 ++
 rtl/core_run_ctrl.sv | 134 +++++++++++++
 tb/tb_core_run_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_run_ctrl_pkg.sv
// Shared types and widths for the slave-core run controller.
// PC width, run-counter width and FSM state encoding live here only.
package core_run_ctrl_pkg;

  localparam int PcWidth   = 16;
  localparam int RunCntW   = 32;
  localparam int FlushCntW = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } run_state_t;

endpackage

// File: rtl/core_run_counter.sv
// Saturating RUN-cycle counter with synchronous clear.
// Clear wins over enable; the count sticks at all-ones.
module core_run_counter
  import core_run_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               i_clr,
  input  logic               i_en,
  output logic [RunCntW-1:0] o_count
);

  logic [RunCntW-1:0] r_count;
  logic               w_sat;

  assign w_sat   = &r_count;
  assign o_count = r_count;

  // count enabled cycles, hold at saturation
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_sat) begin
      r_count <= r_count + RunCntW'(1);
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller for one slave core: flush, PC load, run, drain, done.
// Moore FSM; all outputs decode from registered state and registers.
module core_run_ctrl
  import core_run_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned WATCHDOG     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PcWidth-1:0] start_adr,
  input  logic               halt,
  input  logic               mem_busy,
  output logic               core_en,
  output logic               core_flush,
  output logic               pc_load,
  output logic [PcWidth-1:0] pc_load_val,
  output logic               cpu_end,
  output logic               busy,
  output logic               timed_out,
  output logic [RunCntW-1:0] run_cycles
);

  localparam logic [RunCntW-1:0] WdLast =
    RunCntW'(WATCHDOG - 1);
  localparam logic [FlushCntW-1:0] FlushInit =
    FlushCntW'(FLUSH_CYCLES);

  run_state_t           r_state;
  run_state_t           w_next;
  logic [FlushCntW-1:0] r_flush_cnt;
  logic [PcWidth-1:0]   r_pc;
  logic                 r_timed_out;
  logic                 w_accept;
  logic                 w_wd_hit;
  logic                 w_cnt_clr;
  logic                 w_cnt_en;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state and Moore output decode
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_wd_hit   = 1'b0;
    core_en    = 1'b0;
    core_flush = 1'b0;
    pc_load    = 1'b0;
    cpu_end    = 1'b0;
    busy       = (r_state != ST_IDLE);
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        core_flush = 1'b1;
        if (r_flush_cnt == FlushCntW'(1)) begin
          w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        pc_load = 1'b1;
        w_next  = ST_RUN;
      end
      ST_RUN: begin
        core_en = 1'b1;
        if (halt) begin
          w_next = ST_DRAIN;
        end else if ((WATCHDOG != 0) &&
                     (run_cycles == WdLast)) begin
          w_wd_hit = 1'b1;
          w_next   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!mem_busy) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        cpu_end = 1'b1;
        w_next  = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // launch latch, flush countdown and watchdog flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= '0;
      r_timed_out <= 1'b0;
      r_flush_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_pc        <= start_adr;
        r_timed_out <= 1'b0;
        r_flush_cnt <= FlushInit;
      end else if (r_state == ST_FLUSH) begin
        r_flush_cnt <= r_flush_cnt - FlushCntW'(1);
      end
      if (w_wd_hit) begin
        r_timed_out <= 1'b1;
      end
    end
  end

  assign w_cnt_clr = rst | w_accept;
  assign w_cnt_en  = (r_state == ST_RUN);

  core_run_counter u_cnt (
    .clk     (clk),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_count (run_cycles)
  );

  assign pc_load_val = r_pc;
  assign timed_out   = r_timed_out;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench for core_run_ctrl: run timelines predicted per launch,
// a negedge monitor pops and compares on every pc_load / cpu_end.
module tb_core_run_ctrl;
  import core_run_ctrl_pkg::*;

  localparam int F = 2;
  localparam int W = 10;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [PcWidth-1:0] start_adr;
  logic               halt;
  logic               mem_busy;
  logic               core_en;
  logic               core_flush;
  logic               pc_load;
  logic [PcWidth-1:0] pc_load_val;
  logic               cpu_end;
  logic               busy;
  logic               timed_out;
  logic [RunCntW-1:0] run_cycles;

  core_run_ctrl #(
    .FLUSH_CYCLES (F),
    .WATCHDOG     (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_adr   (start_adr),
    .halt        (halt),
    .mem_busy    (mem_busy),
    .core_en     (core_en),
    .core_flush  (core_flush),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .cpu_end     (cpu_end),
    .busy        (busy),
    .timed_out   (timed_out),
    .run_cycles  (run_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec  = 0;
  int miss = 0;

  typedef struct {
    int                 c;
    logic [PcWidth-1:0] pc;
  } ld_t;

  typedef struct {
    int                 c;
    int                 n;
    bit                 to;
    logic [PcWidth-1:0] pc;
  } end_t;

  ld_t  q_ld[$];
  end_t q_end[$];
  int   fl_cnt = 0;
  int   en_cnt = 0;

  function automatic void chk(string nm, longint act, longint exp);
    vec++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: pop an expectation whenever the DUT presents an event
  always @(negedge clk) begin : mon
    ld_t  le;
    end_t ee;
    if (rst) begin
      fl_cnt = 0;
      en_cnt = 0;
    end else begin
      if (core_flush) fl_cnt++;
      if (core_en) en_cnt++;
      if (pc_load) begin
        if (q_ld.size() == 0) begin
          chk("unexpected_pc_load", 1, 0);
        end else begin
          le = q_ld.pop_front();
          chk("load_cycle", cyc, le.c);
          chk("load_val", pc_load_val, le.pc);
          chk("flush_len", fl_cnt, F);
        end
        fl_cnt = 0;
        en_cnt = 0;
      end
      if (cpu_end) begin
        if (q_end.size() == 0) begin
          chk("unexpected_cpu_end", 1, 0);
        end else begin
          ee = q_end.pop_front();
          chk("end_cycle", cyc, ee.c);
          chk("run_cycles", run_cycles, ee.n);
          chk("timed_out", timed_out, ee.to);
          chk("end_pc_val", pc_load_val, ee.pc);
          chk("core_en_len", en_cnt, ee.n);
        end
        en_cnt = 0;
      end
    end
  end

  // one launch: k = RUN cycle of halt, blen = drain busy cycles
  task automatic run_one(input logic [PcWidth-1:0] adr,
                         input int k, input int blen,
                         input bit bad_start, input bit stray_halt);
    int s, n, e, fin;
    bit to;
    s   = cyc;
    to  = (k > W);
    n   = to ? W : k;
    e   = s + F + 1 + n;
    fin = e + 2 + blen;
    q_ld.push_back('{s + F + 1, adr});
    q_end.push_back('{fin, n, to, adr});
    start     = 1'b1;
    start_adr = adr;
    step();
    while (cyc <= fin) begin
      start     = bad_start && (cyc == s + F + 3);
      start_adr = start ? PcWidth'(16'h0100) : PcWidth'($urandom);
      halt      = (cyc == s + F + 1 + k) ||
                  (stray_halt && (cyc == s + 1));
      mem_busy  = (cyc <= e) ? 1'($urandom) : (cyc < e + 1 + blen);
      step();
    end
    start    = 1'b0;
    halt     = 1'b0;
    mem_busy = 1'b0;
    chk("busy_after_end", busy, 0);
    chk("core_en_after_end", core_en, 0);
  endtask

  // launch, then reset in the third RUN cycle
  task automatic reset_mid_run(input logic [PcWidth-1:0] adr);
    int s;
    s = cyc;
    q_ld.push_back('{s + F + 1, adr});
    start     = 1'b1;
    start_adr = adr;
    step();
    start = 1'b0;
    while (cyc < s + F + 4) step();
    rst = 1'b1;
    step();
    chk("rst_core_en", core_en, 0);
    chk("rst_core_flush", core_flush, 0);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_cpu_end", cpu_end, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timed_out", timed_out, 0);
    chk("rst_pc_val", pc_load_val, 0);
    chk("rst_run_cycles", run_cycles, 0);
    start     = 1'b1;
    start_adr = PcWidth'(16'h0200);
    step();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start_ignored_busy", busy, 0);
    chk("rst_start_ignored_pc", pc_load_val, 0);
    step();
    chk("rst_start_no_flush", core_flush, 0);
    chk("rst_start_idle", busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    start_adr = '0;
    halt      = 1'b0;
    mem_busy  = 1'b0;
    repeat (3) step();
    chk("reset_busy", busy, 0);
    chk("reset_core_en", core_en, 0);
    chk("reset_pc_val", pc_load_val, 0);
    chk("reset_run_cycles", run_cycles, 0);
    chk("reset_timed_out", timed_out, 0);
    rst = 1'b0;
    step();
    run_one(PcWidth'(16'h0040), 6, 0, 1'b0, 1'b0);
    run_one(PcWidth'(16'h0044), 4, 5, 1'b0, 1'b1);
    run_one(PcWidth'(16'h0048), W + 3, 1, 1'b0, 1'b0);
    run_one(PcWidth'(16'h004C), W, 0, 1'b0, 1'b0);
    run_one(PcWidth'(16'h0050), 7, 2, 1'b1, 1'b0);
    reset_mid_run(PcWidth'(16'h0060));
    run_one(PcWidth'(16'h0080), 5, 0, 1'b0, 1'b0);
    run_one(PcWidth'(16'h0010), 3, 0, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 2)) step();
      run_one(PcWidth'($urandom),
              int'($urandom_range(1, W + 3)),
              int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end
    repeat (4) step();
    chk("pending_loads", q_ld.size(), 0);
    chk("pending_ends", q_end.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
